// File: rtl/uart_rx_flow.sv
`timescale 1ns/1ps
// uart_rx_flow: 8N1 UART receiver (LSB first) feeding a first-word-fall-through
// byte FIFO, with RTS hysteresis on FIFO occupancy and one-cycle monitor pulses.
module uart_rx_flow #(
  parameter int FIFO_DEPTH     = 16,
  parameter int RTS_HIGH_WATER = 12,
  parameter int RTS_LOW_WATER  = 4,
  parameter int MIN_DIVISOR    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_rx,
  input  logic [15:0]                 baud_divisor,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        rx_error,
  output logic                        rx_overrun,
  output logic                        byte_received,
  output logic                        uart_rts_n,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  logic [15:0]     timer_q, timer_d;
  logic [15:0]     div_q, div_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            err_q, err_d;
  logic            ovr_q, ovr_d;
  logic            brx_q, brx_d;
  logic            rts_q, rts_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic [15:0]     div_eff_s;
  logic            start_s;
  logic            push_req_s;
  logic            frame_err_s;
  logic            pop_s;
  logic            full_s;
  logic            push_ok_s;

  // Synchroniser chain, divisor floor and start-edge detection.
  always_comb begin
    sync1_d   = uart_rx;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    start_s   = (sync2_q == 1'b0) && (prev_q == 1'b1);
    if (baud_divisor < 16'(MIN_DIVISOR)) begin
      div_eff_s = 16'(MIN_DIVISOR);
    end else begin
      div_eff_s = baud_divisor;
    end
  end

  // Receive state machine: mid-bit sampling driven by a down-counting bit timer.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    div_d       = div_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    push_req_s  = 1'b0;
    frame_err_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          div_d   = div_eff_s;
          timer_d = (div_eff_s >> 1) - 16'd1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (timer_q == 16'd0) begin
          if (sync2_q) begin
            state_d = S_IDLE;
          end else begin
            timer_d = div_q - 16'd1;
            idx_d   = 3'd0;
            state_d = S_DATA;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        if (timer_q == 16'd0) begin
          shreg_d[idx_q] = sync2_q;
          timer_d        = div_q - 16'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STOP: begin
        if (timer_q == 16'd0) begin
          if (sync2_q) begin
            push_req_s = 1'b1;
            state_d    = S_IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (sync2_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping, registered head/valid, monitor pulses and RTS hysteresis.
  always_comb begin
    pop_s     = rx_valid_q && rx_ready;
    full_s    = (count_q == CW'(FIFO_DEPTH));
    push_ok_s = push_req_s && (!full_s || pop_s);
    ovr_d     = push_req_s && full_s && !pop_s;
    brx_d     = push_ok_s;
    err_d     = frame_err_s;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rx_valid_d = (count_d != CW'(0));
    // The byte being written is the new head when it lands on the next read slot.
    if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      rx_data_d = shreg_q;
    end else begin
      rx_data_d = mem_q[rd_ptr_d];
    end
    if (count_d >= CW'(RTS_HIGH_WATER)) begin
      rts_d = 1'b1;
    end else if (count_d <= CW'(RTS_LOW_WATER)) begin
      rts_d = 1'b0;
    end else begin
      rts_d = rts_q;
    end
  end

  // FIFO storage; contents are logically discarded by the pointer reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= shreg_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      timer_q    <= 16'd0;
      div_q      <= 16'd0;
      idx_q      <= 3'd0;
      shreg_q    <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      brx_q      <= 1'b0;
      rts_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      brx_q      <= brx_d;
      rts_q      <= rts_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_error      = err_q;
  assign rx_overrun    = ovr_q;
  assign byte_received = brx_q;
  assign uart_rts_n    = rts_q;
  assign fifo_count    = count_q;

endmodule
